vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 187 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/blanking generator with a small built-in test
// pattern source (black, colour bars, checkerboard, solid colour).
//
// Ports
//   vgaclk        pixel clock, the only clock
//   resetn        synchronous active-low reset
//   enable        run the raster when high; low parks it at (0,0), outputs idle
//   mode          pattern: 0 black, 1 colour bars, 2 checkerboard, 3 solid
//   solid_rgb     {r,g,b} used in mode 3
//   hsync, vsync  sync pulses, active level HS_POL / VS_POL
//   hden, vden    horizontal / vertical active region, de = hden & vden
//   x, y          coordinate of the pixel on the outputs (0 outside active)
//   r, g, b       pixel colour, 0 outside active area and during startup blanking
//   frame_start   one-clock pulse aligned with pixel (0,0)
//   startup_done  sticky, high once BLANK_FRAMES frames have completed
//
// All outputs are registered from the current counter values, so every
// output carries exactly one clock of latency and they stay mutually aligned.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter bit          HS_POL       = 1'b0,
  parameter bit          VS_POL       = 1'b0,
  parameter int unsigned BLANK_FRAMES = 10,
  parameter int unsigned CW           = 10,
  parameter int unsigned COLOR_W      = 4,
  parameter int unsigned CHK_LOG2     = 5
) (
  input  logic                   vgaclk,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   hden,
  output logic                   vden,
  output logic                   de,
  output logic [CW-1:0]          x,
  output logic [CW-1:0]          y,
  output logic [COLOR_W-1:0]     r,
  output logic [COLOR_W-1:0]     g,
  output logic [COLOR_W-1:0]     b,
  output logic                   frame_start,
  output logic                   startup_done
);

  localparam int unsigned H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = V_ACTIVE + V_FP + V_SYNC;
  localparam int unsigned RGB_W  = 3 * COLOR_W;
  localparam int unsigned BAR_W  = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  // Frame counter only needs to reach BLANK_FRAMES; keep at least one bit.
  localparam int unsigned FW     = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;

  logic [CW-1:0]    hcnt;
  logic [CW-1:0]    vcnt;
  logic [FW-1:0]    frame_cnt;
  logic [1:0]       mode_q;
  logic [RGB_W-1:0] solid_q;

  logic             h_last_c;
  logic             v_last_c;
  logic             origin_c;
  logic             blank_done_c;
  logic             hden_c;
  logic             vden_c;
  logic             de_c;
  logic             hs_act_c;
  logic             vs_act_c;
  logic [1:0]       mode_c;
  logic [RGB_W-1:0] solid_c;
  logic [CW-1:0]    bar_c;
  logic [2:0]       bar_idx_c;
  logic [RGB_W-1:0] pix_c;

  // Region decode and pattern generation from the current counter values.
  always_comb begin
    h_last_c     = (hcnt == CW'(H_TOT - 1));
    v_last_c     = (vcnt == CW'(V_TOT - 1));
    origin_c     = (hcnt == '0) && (vcnt == '0);
    // Counter saturates at BLANK_FRAMES, so equality means "blanking over".
    blank_done_c = (frame_cnt == FW'(BLANK_FRAMES));
    hden_c       = (hcnt < CW'(H_ACTIVE));
    vden_c       = (vcnt < CW'(V_ACTIVE));
    de_c         = hden_c && vden_c;
    hs_act_c     = (hcnt >= CW'(HS_BEG)) && (hcnt < CW'(HS_END));
    vs_act_c     = (vcnt >= CW'(VS_BEG)) && (vcnt < CW'(VS_END));

    // Pixel (0,0) already uses the values being latched for the new frame.
    mode_c       = origin_c ? mode : mode_q;
    solid_c      = origin_c ? solid_rgb : solid_q;

    // Remainder pixels past 8 full bars fold into the last (black) bar.
    bar_c        = hcnt / CW'(BAR_W);
    bar_idx_c    = (bar_c > CW'(7)) ? 3'd7 : bar_c[2:0];

    pix_c = '0;
    unique case (mode_c)
      // Bar order white..black: r = ~idx[1], g = ~idx[2], b = ~idx[0].
      2'd1:    pix_c = {{COLOR_W{~bar_idx_c[1]}}, {COLOR_W{~bar_idx_c[2]}},
                        {COLOR_W{~bar_idx_c[0]}}};
      2'd2:    pix_c = (hcnt[CHK_LOG2] ^ vcnt[CHK_LOG2]) ? '0 : '1;
      2'd3:    pix_c = solid_c;
      default: pix_c = '0;
    endcase
    if (!de_c || !blank_done_c) begin
      pix_c = '0;
    end
  end

  // Raster counters, per-frame pattern latch and startup frame counter.
  always_ff @(posedge vgaclk) begin
    if (!resetn) begin
      hcnt      <= '0;
      vcnt      <= '0;
      frame_cnt <= '0;
      mode_q    <= '0;
      solid_q   <= '0;
    end else if (!enable) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      if (origin_c) begin
        mode_q  <= mode;
        solid_q <= solid_rgb;
      end
      if (h_last_c) begin
        hcnt <= '0;
        vcnt <= v_last_c ? '0 : vcnt + CW'(1);
        if (v_last_c && !blank_done_c) begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end else begin
        hcnt <= hcnt + CW'(1);
      end
    end
  end

  // Output registers, one clock behind the counters.
  always_ff @(posedge vgaclk) begin
    if (!resetn) begin
      hsync        <= ~HS_POL;
      vsync        <= ~VS_POL;
      hden         <= 1'b0;
      vden         <= 1'b0;
      de           <= 1'b0;
      x            <= '0;
      y            <= '0;
      {r, g, b}    <= '0;
      frame_start  <= 1'b0;
      startup_done <= (BLANK_FRAMES == 0);
    end else if (!enable) begin
      hsync        <= ~HS_POL;
      vsync        <= ~VS_POL;
      hden         <= 1'b0;
      vden         <= 1'b0;
      de           <= 1'b0;
      x            <= '0;
      y            <= '0;
      {r, g, b}    <= '0;
      frame_start  <= 1'b0;
      startup_done <= blank_done_c;
    end else begin
      hsync        <= hs_act_c ? HS_POL : ~HS_POL;
      vsync        <= vs_act_c ? VS_POL : ~VS_POL;
      hden         <= hden_c;
      vden         <= vden_c;
      de           <= de_c;
      x            <= de_c ? hcnt : '0;
      y            <= de_c ? vcnt : '0;
      {r, g, b}    <= pix_c;
      frame_start  <= origin_c;
      startup_done <= blank_done_c;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-raster instances (A: blanking + active-low
// syncs, B: no blanking + active-high syncs) compared every clock against a
// position-based reference model, plus directed spot checks.
module tb_vga_timing_gen;

  localparam int HA = 68, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 40, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int BW = HA / 8;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic [1:0]  mode;
  logic [11:0] solid;

  logic hsync_a, vsync_a, hden_a, vden_a, de_a, fs_a, sd_a;
  logic hsync_b, vsync_b, hden_b, vden_b, de_b, fs_b, sd_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .BLANK_FRAMES(2),
    .CW(10), .COLOR_W(4), .CHK_LOG2(3)
  ) dut_a (
    .vgaclk(clk), .resetn(resetn), .enable(enable), .mode(mode), .solid_rgb(solid),
    .hsync(hsync_a), .vsync(vsync_a), .hden(hden_a), .vden(vden_a), .de(de_a),
    .x(x_a), .y(y_a), .r(r_a), .g(g_a), .b(b_a),
    .frame_start(fs_a), .startup_done(sd_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .BLANK_FRAMES(0),
    .CW(10), .COLOR_W(4), .CHK_LOG2(3)
  ) dut_b (
    .vgaclk(clk), .resetn(resetn), .enable(enable), .mode(mode), .solid_rgb(solid),
    .hsync(hsync_b), .vsync(vsync_b), .hden(hden_b), .vden(vden_b), .de(de_b),
    .x(x_b), .y(y_b), .r(r_b), .g(g_b), .b(b_b),
    .frame_start(fs_b), .startup_done(sd_b)
  );

  logic [38:0] word_a, word_b;
  assign word_a = {hsync_a, vsync_a, hden_a, vden_a, de_a, x_a, y_a, r_a, g_a, b_a, fs_a, sd_a};
  assign word_b = {hsync_b, vsync_b, hden_b, vden_b, de_b, x_b, y_b, r_b, g_b, b_b, fs_b, sd_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: position within the frame, completed-frame count, latched pattern.
  int          blank_p [2] = '{2, 0};
  bit          pol_p   [2] = '{1'b0, 1'b1};
  int          m_pos   [2];
  int          m_frames[2];
  logic [1:0]  m_mode  [2];
  logic [11:0] m_solid [2];
  logic [38:0] exp_w   [2];
  logic [11:0] bar_rgb [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                               12'hF0F, 12'hF00, 12'h00F, 12'h000};
  bit out_valid;
  int out_hc, out_vc;

  function automatic logic [38:0] pk(logic hs, logic vs, logic hd, logic vd, logic d,
                                     int xv, int yv, logic [11:0] c, logic fs, logic sd);
    return {hs, vs, hd, vd, d, 10'(xv), 10'(yv), c, fs, sd};
  endfunction

  task automatic step(input int d);
    int hc, vc, bar;
    logic hd, vd, act, hs, vs;
    logic [11:0] c;
    bit pol;
    pol = pol_p[d];
    if (!resetn) begin
      exp_w[d] = pk(~pol, ~pol, 0, 0, 0, 0, 0, 12'h0, 0, blank_p[d] == 0);
      m_pos[d] = 0; m_frames[d] = 0; m_mode[d] = 2'd0; m_solid[d] = 12'h0;
      if (d == 0) out_valid = 0;
    end else if (!enable) begin
      exp_w[d] = pk(~pol, ~pol, 0, 0, 0, 0, 0, 12'h0, 0, m_frames[d] >= blank_p[d]);
      m_pos[d] = 0;
      if (d == 0) out_valid = 0;
    end else begin
      hc = m_pos[d] % HT;
      vc = m_pos[d] / HT;
      if (m_pos[d] == 0) begin
        m_mode[d]  = mode;
        m_solid[d] = solid;
      end
      hd  = hc < HA;
      vd  = vc < VA;
      act = hd && vd;
      hs  = (hc >= HA + HFP && hc < HA + HFP + HS) ? pol : ~pol;
      vs  = (vc >= VA + VFP && vc < VA + VFP + VS) ? pol : ~pol;
      c   = 12'h0;
      if (act && m_frames[d] >= blank_p[d]) begin
        case (m_mode[d])
          2'd1: begin
            bar = hc / BW;
            if (bar > 7) bar = 7;
            c = bar_rgb[bar];
          end
          2'd2: c = ((((hc / 8) + (vc / 8)) % 2) == 0) ? 12'hFFF : 12'h000;
          2'd3: c = m_solid[d];
          default: c = 12'h0;
        endcase
      end
      exp_w[d] = pk(hs, vs, hd, vd, act, act ? hc : 0, act ? vc : 0, c,
                    m_pos[d] == 0, m_frames[d] >= blank_p[d]);
      if (d == 0) begin
        out_valid = 1; out_hc = hc; out_vc = vc;
      end
      m_pos[d]++;
      if (m_pos[d] == FRAME) begin
        m_pos[d] = 0;
        if (m_frames[d] < 1000) m_frames[d]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    step(0);
    step(1);
    @(negedge clk);
    check("cyc_a", word_a, exp_w[0]);
    check("cyc_b", word_b, exp_w[1]);
  endtask

  task automatic wait_pixel(input int hx, input int vy);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(out_valid && out_hc == hx && out_vc == vy) && n < 2 * FRAME + 100);
    if (!(out_valid && out_hc == hx && out_vc == vy)) check("wait_timeout", 0, 1);
  endtask

  // Sync/de statistics over one frame of A, starting on pixel (0,0).
  task automatic measure_a();
    int hs_n, vs_n, de_n, hs_on, vs_on, first, second;
    logic prev_hs, prev_vs;
    hs_n = 0; vs_n = 0; de_n = 0; hs_on = 0; vs_on = 0; first = -1; second = -1;
    prev_hs = 1'b1; prev_vs = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      if (!hsync_a) hs_n++;
      if (!vsync_a) vs_n++;
      if (de_a) de_n++;
      if (prev_hs && !hsync_a) begin
        hs_on++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      if (prev_vs && !vsync_a) vs_on++;
      prev_hs = hsync_a;
      prev_vs = vsync_a;
      tick();
    end
    check("hs_active_clks", hs_n, VT * HS);
    check("hs_period", second - first, HT);
    check("hs_pulses", hs_on, VT);
    check("vs_active_clks", vs_n, VS * HT);
    check("vs_pulses", vs_on, 1);
    check("de_clks", de_n, HA * VA);
  endtask

  initial begin
    int off_left;
    resetn = 1'b0; enable = 1'b0; mode = 2'd0; solid = 12'h0;
    off_left = 0;
    repeat (3) tick();
    check("reset_a", word_a, pk(1, 1, 0, 0, 0, 0, 0, 12'h0, 0, 0));
    check("reset_b", word_b, pk(0, 0, 0, 0, 0, 0, 0, 12'h0, 0, 1));
    resetn = 1'b1;
    tick();
    check("idle_a", word_a, pk(1, 1, 0, 0, 0, 0, 0, 12'h0, 0, 0));

    // Startup blanking on A, immediate colour on B.
    mode = 2'd3; solid = 12'hFFF; enable = 1'b1;
    tick();
    check("first_fs_a", fs_a, 1);
    wait_pixel(5, 5);
    check("blank_rgb_a", {r_a, g_a, b_a}, 12'h000);
    check("rgb_b", {r_b, g_b, b_b}, 12'hFFF);
    check("sd_a_early", sd_a, 0);
    check("sd_b_early", sd_b, 1);
    wait_pixel(HA + HFP, 5);
    check("hs_low_a", hsync_a, 0);
    check("hs_high_b", hsync_b, 1);
    wait_pixel(HT - 1, VT - 1);
    wait_pixel(60, 30);
    check("blank_rgb_a_f1", {r_a, g_a, b_a}, 12'h000);
    wait_pixel(HT - 1, VT - 1);
    check("sd_a_f1_end", sd_a, 0);
    tick();
    check("f2_fs_a", fs_a, 1);
    check("f2_sd_a", sd_a, 1);
    check("f2_rgb_a", {r_a, g_a, b_a}, 12'hFFF);

    // Timing statistics while switching to bars for the next frame.
    mode = 2'd1;
    measure_a();
    check("bar_x0", {r_a, g_a, b_a}, 12'hFFF);
    wait_pixel(BW - 1, 0);
    check("bar_white_end", {r_a, g_a, b_a}, 12'hFFF);
    wait_pixel(BW, 0);
    check("bar_yellow", {r_a, g_a, b_a}, 12'hFF0);
    wait_pixel(2 * BW, 0);
    check("bar_cyan", {r_a, g_a, b_a}, 12'h0FF);
    wait_pixel(7 * BW - 1, 0);
    check("bar_blue", {r_a, g_a, b_a}, 12'h00F);
    wait_pixel(HA - 1, 0);
    check("bar_last_black", {r_a, g_a, b_a}, 12'h000);

    // Mode change mid-frame takes effect only at the next frame.
    wait_pixel(0, 10);
    mode = 2'd2;
    wait_pixel(BW, 20);
    check("no_tear", {r_a, g_a, b_a}, 12'hFF0);
    wait_pixel(0, 0);
    check("chk_00", {r_a, g_a, b_a}, 12'hFFF);
    wait_pixel(8, 0);
    check("chk_80", {r_a, g_a, b_a}, 12'h000);
    wait_pixel(0, 8);
    check("chk_08", {r_a, g_a, b_a}, 12'h000);
    wait_pixel(8, 8);
    check("chk_88", {r_a, g_a, b_a}, 12'hFFF);

    // Enable dropped mid-line for 50 clocks.
    wait_pixel(30, 5);
    enable = 1'b0;
    repeat (50) tick();
    check("dis_hs_a", hsync_a, 1);
    check("dis_hs_b", hsync_b, 0);
    check("dis_de_a", de_a, 0);
    check("dis_fs_a", fs_a, 0);
    enable = 1'b1;
    tick();
    check("reen_fs_a", fs_a, 1);
    check("reen_xy_a", {x_a, y_a}, 20'h0);
    check("reen_sd_a", sd_a, 1);
    check("reen_rgb_a", {r_a, g_a, b_a}, 12'hFFF);

    // Randomized pattern changes and enable drops.
    mode = 2'd3; solid = 12'($urandom);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ($urandom_range(499, 0) == 0) begin
        mode  = 2'($urandom_range(3, 0));
        solid = 12'($urandom);
      end
      if (!enable) begin
        if (off_left == 0) enable = 1'b1;
        else off_left--;
      end else if ($urandom_range(1999, 0) == 0) begin
        enable   = 1'b0;
        off_left = $urandom_range(40, 1);
      end
      tick();
    end
    enable = 1'b1;

    // Reset mid-frame restarts the raster and the blanking sequence.
    mode = 2'd3; solid = 12'h5A3;
    wait_pixel(20, 15);
    resetn = 1'b0;
    tick();
    tick();
    check("rst2_a", word_a, pk(1, 1, 0, 0, 0, 0, 0, 12'h0, 0, 0));
    check("rst2_b", word_b, pk(0, 0, 0, 0, 0, 0, 0, 12'h0, 0, 1));
    resetn = 1'b1;
    wait_pixel(3, 3);
    check("rst2_blank_a", {r_a, g_a, b_a}, 12'h000);
    check("rst2_rgb_b", {r_b, g_b, b_b}, 12'h5A3);
    check("rst2_sd_a", sd_a, 0);
    check("rst2_sd_b", sd_b, 1);
    wait_pixel(0, 0);
    check("rst2_f1_sd_a", sd_a, 0);
    wait_pixel(0, 0);
    check("rst2_f2_fs_a", fs_a, 1);
    check("rst2_f2_sd_a", sd_a, 1);
    wait_pixel(3, 3);
    check("rst2_f2_rgb_a", {r_a, g_a, b_a}, 12'h5A3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
